dffram_march_bist: RTL and testbench

March C- built-in self-test controller that sits directly upstream of DFFRAM256x32 and owns its port 0 (CLK/EN0/WE0/A0/Di0/Do0).
- Idle: transparent pass-through mux; functional master requests go straight to the RAM.
- On a start pulse: takes the port, runs a full March C- sequence with data backgrounds 0x00000000 / 0xFFFFFFFF, and compares read data in a latency-matched pipeline.
- Reports pass/fail, an error count, and the first failing address/data.

---
 rtl/dffram_march_bist_if.sv | 17 +
 rtl/dffram_march_bist.sv | 205 ++++++++++++++++++++
 tb/tb_dffram_march_bist.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dffram_march_bist_if.sv
// Single-port DFFRAM port bundle (EN0/WE0/A0/Di0/Do0).
// master drives the request and receives read data. slave is the RAM-facing side.
interface dffram_march_bist_if #(
    parameter int unsigned WSIZE  = 4,
    parameter int unsigned AWIDTH = 8
);
    localparam int unsigned DW = WSIZE * 8;

    logic              EN0;
    logic [WSIZE-1:0]  WE0;
    logic [AWIDTH-1:0] A0;
    logic [DW-1:0]     Di0;
    logic [DW-1:0]     Do0;

    modport master (output EN0, output WE0, output A0, output Di0, input Do0);
    modport slave  (input EN0, input WE0, input A0, input Di0, output Do0);
endinterface

// File: rtl/dffram_march_bist.sv
// March C- BIST controller owning port 0 of a DFFRAM.
// While idle, the functional requester passes straight through to the RAM.
// A start pulse runs the march with 0/all-ones backgrounds. Reads are checked
// RD_LAT edges after the RAM samples them.
module dffram_march_bist #(
    parameter int unsigned WSIZE  = 4,
    parameter int unsigned BANKS  = 16,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ERR_W  = 8,
    localparam int unsigned DW     = WSIZE * 8,
    localparam int unsigned AWIDTH = $clog2(BANKS) + 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [AWIDTH-1:0]    fail_addr,
    output logic [DW-1:0]        fail_data,
    output logic [DW-1:0]        fail_exp,
    dffram_march_bist_if.slave   sys,
    dffram_march_bist_if.master  ram
);

    typedef enum logic [3:0] {
        StIdle, StE0, StE1, StE2, StE3, StE4, StE5, StDrain, StDone
    } state_e;

    localparam logic [AWIDTH-1:0] ADDR_MAX = '1;

    state_e            state_q;
    logic [AWIDTH-1:0] addr_q;   // march address, reused as the drain counter
    logic              phase_q;  // r/w elements: 0 = read slot, 1 = write slot
    logic              busy_q;
    logic              done_q;

    logic start_acc;
    logic op_rd;   // current BIST op is a read
    logic op_bg;   // background bit: write value, or expected value for a read
    logic op_en;

    assign start_acc = start && ((state_q == StIdle) || (state_q == StDone));
    assign op_en     = busy_q && (state_q != StDrain);

    // Decode the current op of the active march element.
    always_comb begin
        op_rd = 1'b0;
        op_bg = 1'b0;
        case (state_q)
            StE1, StE3: begin  // (r0,w1)
                op_rd = !phase_q;
                op_bg = phase_q;
            end
            StE2, StE4: begin  // (r1,w0)
                op_rd = !phase_q;
                op_bg = !phase_q;
            end
            StE5:    op_rd = 1'b1;
            default: ;
        endcase
    end

    // Sequencer: element order, address direction, read/write slot and drain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            addr_q  <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StE0;
                        addr_q  <= '0;
                        phase_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                StE0: begin
                    if (addr_q == ADDR_MAX) begin
                        state_q <= StE1;
                        addr_q  <= '0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                StE1, StE2: begin
                    phase_q <= !phase_q;
                    if (phase_q) begin
                        if (addr_q != ADDR_MAX) begin
                            addr_q <= addr_q + 1'b1;
                        end else if (state_q == StE1) begin
                            state_q <= StE2;
                            addr_q  <= '0;
                        end else begin
                            state_q <= StE3;
                            addr_q  <= ADDR_MAX;
                        end
                    end
                end
                StE3, StE4: begin
                    phase_q <= !phase_q;
                    if (phase_q) begin
                        if (addr_q != '0) begin
                            addr_q <= addr_q - 1'b1;
                        end else if (state_q == StE3) begin
                            state_q <= StE4;
                            addr_q  <= ADDR_MAX;
                        end else begin
                            state_q <= StE5;
                            addr_q  <= '0;
                        end
                    end
                end
                StE5: begin
                    if (addr_q == ADDR_MAX) begin
                        state_q <= StDrain;
                        addr_q  <= '0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                StDrain: begin
                    // Holds until the final read has been compared.
                    if (addr_q == AWIDTH'(RD_LAT)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Compare pipeline: stage RD_LAT-1 lines up with Do0 of the read it tracks.
    logic [RD_LAT-1:0]             pv_q;
    logic [RD_LAT-1:0]             pb_q;
    logic [RD_LAT-1:0][AWIDTH-1:0] pa_q;
    logic [ERR_W-1:0]              err_q;
    logic [DW-1:0]                 cmp_exp;
    logic                          mismatch;

    assign cmp_exp  = {DW{pb_q[RD_LAT-1]}};
    // Case inequality so that X/Z on Do0 is reported as a failure.
    assign mismatch = pv_q[RD_LAT-1] && (ram.Do0 !== cmp_exp);

    // Track outstanding reads, count mismatches and latch the first one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pv_q      <= '0;
            pb_q      <= '0;
            pa_q      <= '0;
            err_q     <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_exp  <= '0;
        end else if (start_acc) begin
            pv_q      <= '0;
            err_q     <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_exp  <= '0;
        end else begin
            pv_q[0] <= op_rd;
            pb_q[0] <= op_bg;
            pa_q[0] <= addr_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pv_q[i] <= pv_q[i-1];
                pb_q[i] <= pb_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
            if (mismatch) begin
                if (err_q != '1) begin
                    err_q <= err_q + 1'b1;
                end
                if (err_q == '0) begin
                    fail_addr <= pa_q[RD_LAT-1];
                    fail_data <= ram.Do0;
                    fail_exp  <= cmp_exp;
                end
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_q;
    assign pass    = done_q && (err_q == '0);

    // Port 0 mux: the BIST owns the RAM only while busy.
    assign ram.EN0 = busy_q ? op_en : sys.EN0;
    assign ram.WE0 = busy_q ? ((op_en && !op_rd) ? {WSIZE{1'b1}} : {WSIZE{1'b0}}) : sys.WE0;
    assign ram.A0  = busy_q ? addr_q : sys.A0;
    assign ram.Di0 = busy_q ? {DW{op_bg}} : sys.Di0;
    assign sys.Do0 = ram.Do0;

endmodule

// File: tb/tb_dffram_march_bist.sv
// Directed bench for dffram_march_bist with behavioural DFFRAM models.
// u_dut uses RD_LAT=1. u_dut2 uses RD_LAT=2 and shares clock, reset and start.
module tb_dffram_march_bist;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic start = 1'b0;

    always #5 CLK = ~CLK;

    dffram_march_bist_if #(.WSIZE(4), .AWIDTH(8)) sys1 ();
    dffram_march_bist_if #(.WSIZE(4), .AWIDTH(8)) ram1 ();
    dffram_march_bist_if #(.WSIZE(4), .AWIDTH(8)) sys2 ();
    dffram_march_bist_if #(.WSIZE(4), .AWIDTH(8)) ram2 ();

    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0]  err1, err2, faddr1, faddr2;
    logic [31:0] fdata1, fexp1, fdata2, fexp2;

    dffram_march_bist #(.WSIZE(4), .BANKS(16), .RD_LAT(1), .ERR_W(8)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_addr(faddr1), .fail_data(fdata1), .fail_exp(fexp1),
        .sys(sys1), .ram(ram1)
    );

    dffram_march_bist #(.WSIZE(4), .BANKS(16), .RD_LAT(2), .ERR_W(8)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_addr(faddr2), .fail_data(fdata2), .fail_exp(fexp2),
        .sys(sys2), .ram(ram2)
    );

    // RAM models: byte-masked write, registered read, optional stuck-at faults on ram1.
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    logic [31:0] rd2_stage;
    bit          scramble = 1'b0;
    logic [31:0] sa1_mask = '0;
    logic [7:0]  sa1_addr = '0;
    logic [31:0] sa0_mask = '0;

    function automatic logic [31:0] faulty(input logic [31:0] d, input logic [7:0] a);
        logic [31:0] r;
        r = (a == sa1_addr) ? (d | sa1_mask) : d;
        return r & ~sa0_mask;
    endfunction

    always @(posedge CLK) begin
        if (scramble) begin
            for (int i = 0; i < 256; i++) mem1[i] <= $urandom();
        end else if (ram1.EN0) begin
            for (int b = 0; b < 4; b++)
                if (ram1.WE0[b]) mem1[ram1.A0][8*b +: 8] <= ram1.Di0[8*b +: 8];
            ram1.Do0 <= faulty(mem1[ram1.A0], ram1.A0);
        end
    end

    always @(posedge CLK) begin
        if (scramble) begin
            for (int i = 0; i < 256; i++) mem2[i] <= $urandom();
        end else if (ram2.EN0) begin
            for (int b = 0; b < 4; b++)
                if (ram2.WE0[b]) mem2[ram2.A0][8*b +: 8] <= ram2.Di0[8*b +: 8];
            rd2_stage <= mem2[ram2.A0];
        end
        ram2.Do0 <= rd2_stage;
    end

    // Scoreboard of expected values and the comparison counters.
    logic [31:0] sb [$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic expect_val(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic sys_idle();
        sys1.EN0 = 1'b0; sys1.WE0 = 4'h0; sys1.A0 = 8'h00; sys1.Di0 = 32'h0;
    endtask

    task automatic sys_write(input logic [7:0] a, input logic [31:0] d);
        sys1.EN0 = 1'b1; sys1.WE0 = 4'hF; sys1.A0 = a; sys1.Di0 = d;
        @(posedge CLK); #1;
        sys_idle();
    endtask

    task automatic sys_read_check(input string tag, input logic [7:0] a,
                                  input logic [31:0] exp);
        expect_val(exp);
        sys1.EN0 = 1'b1; sys1.WE0 = 4'h0; sys1.A0 = a;
        @(posedge CLK); #1;
        sys_idle();
        check(tag, sys1.Do0);
    endtask

    task automatic check_cleared(input string tag);
        expect_val(0); check({tag, "_busy"}, 32'(busy1));
        expect_val(0); check({tag, "_done"}, 32'(done1));
        expect_val(0); check({tag, "_pass"}, 32'(pass1));
        expect_val(0); check({tag, "_err"}, 32'(err1));
        expect_val(0); check({tag, "_faddr"}, 32'(faddr1));
        expect_val(0); check({tag, "_fdata"}, fdata1);
        expect_val(0); check({tag, "_fexp"}, fexp1);
    endtask

    // Pulse start and count cycles from T0 until each DUT raises done.
    task automatic run(input bit disturb, output int c1, output int c2);
        c1 = 0;
        c2 = 0;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        expect_val(1); check("busy_after_start", 32'(busy1));
        expect_val(0); check("done_cleared_on_start", 32'(done1));
        if (disturb) begin
            sys1.EN0 = 1'b1; sys1.WE0 = 4'hF; sys1.A0 = 8'h40; sys1.Di0 = 32'hDEADBEEF;
        end
        for (int cyc = 1; cyc <= 3000 && (c1 == 0 || c2 == 0); cyc++) begin
            start = disturb && (cyc == 10);
            @(posedge CLK); #1;
            if (c1 == 0 && done1) begin
                c1 = cyc;
                sys_idle();
            end
            if (c2 == 0 && done2) c2 = cyc;
        end
        start = 1'b0;
        sys_idle();
    endtask

    function automatic int count_nonzero1();
        int nz = 0;
        for (int i = 0; i < 256; i++) if (mem1[i] !== 32'h0) nz++;
        return nz;
    endfunction

    function automatic int count_nonzero2();
        int nz = 0;
        for (int i = 0; i < 256; i++) if (mem2[i] !== 32'h0) nz++;
        return nz;
    endfunction

    int c1, c2;

    initial begin
        sys_idle();
        sys2.EN0 = 1'b0; sys2.WE0 = 4'h0; sys2.A0 = 8'h00; sys2.Di0 = 32'h0;
        #1;
        check_cleared("reset");
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        // 1: functional pass-through while idle
        sys_write(8'h12, 32'hAA0055BB);
        sys_read_check("idle_readback", 8'h12, 32'hAA0055BB);
        expect_val(0); check("idle_busy", 32'(busy1));
        expect_val(0); check("idle_done", 32'(done1));

        // 2: clean run over a scrambled RAM
        scramble = 1'b1;
        @(posedge CLK); #1;
        scramble = 1'b0;
        run(1'b0, c1, c2);
        expect_val(2562); check("clean_run_len", 32'(c1));
        expect_val(2563); check("clean_run_len_lat2", 32'(c2));
        expect_val(1); check("clean_pass", 32'(pass1));
        expect_val(0); check("clean_err", 32'(err1));
        expect_val(0); check("clean_busy_after", 32'(busy1));
        expect_val(1); check("clean_pass_lat2", 32'(pass2));
        expect_val(0); check("clean_ram_zero", 32'(count_nonzero1()));
        expect_val(0); check("clean_ram_zero_lat2", 32'(count_nonzero2()));

        // 3: bit 5 of 0x37 stuck at 1
        sa1_addr = 8'h37;
        sa1_mask = 32'h0000_0020;
        run(1'b0, c1, c2);
        sa1_mask = 32'h0;
        expect_val(2562); check("sa1_run_len", 32'(c1));
        expect_val(3); check("sa1_err", 32'(err1));
        expect_val(32'h37); check("sa1_faddr", 32'(faddr1));
        expect_val(32'h0000_0000); check("sa1_fexp", fexp1);
        expect_val(32'h0000_0020); check("sa1_fdata", fdata1);
        expect_val(0); check("sa1_pass", 32'(pass1));
        expect_val(1); check("sa1_done", 32'(done1));

        // 4: bit 31 stuck at 0 everywhere, counter saturates
        sa0_mask = 32'h8000_0000;
        run(1'b0, c1, c2);
        expect_val(255); check("sa0_err_sat", 32'(err1));
        expect_val(32'h00); check("sa0_faddr", 32'(faddr1));
        expect_val(32'hFFFF_FFFF); check("sa0_fexp", fexp1);
        expect_val(32'h7FFF_FFFF); check("sa0_fdata", fdata1);
        expect_val(0); check("sa0_pass", 32'(pass1));

        // 5: reset in the middle of E2 (errors already accumulating)
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (900) @(posedge CLK);
        #1;
        expect_val(1); check("mid_busy_before_reset", 32'(busy1));
        RST_N = 1'b0;
        sys1.EN0 = 1'b1; sys1.WE0 = 4'h0; sys1.A0 = 8'h5A;
        #1;
        check_cleared("midreset");
        expect_val(32'h5A); check("midreset_passthru_a", 32'(ram1.A0));
        expect_val(1); check("midreset_passthru_en", 32'(ram1.EN0));
        expect_val(0); check("midreset_passthru_we", 32'(ram1.WE0));
        @(posedge CLK); #1;
        sys_idle();
        RST_N = 1'b1;
        sa0_mask = 32'h0;
        sys_write(8'h21, 32'h1234_5678);
        sys_read_check("postreset_readback", 8'h21, 32'h1234_5678);
        run(1'b0, c1, c2);
        expect_val(2562); check("postreset_run_len", 32'(c1));
        expect_val(1); check("postreset_pass", 32'(pass1));

        // 6: start re-pulsed and functional writes attempted while busy
        run(1'b1, c1, c2);
        expect_val(2562); check("disturb_run_len", 32'(c1));
        expect_val(2563); check("disturb_run_len_lat2", 32'(c2));
        expect_val(1); check("disturb_pass", 32'(pass1));
        expect_val(32'h0); check("disturb_no_stray_write", mem1[8'h40]);
        expect_val(0); check("disturb_ram_zero", 32'(count_nonzero1()));
        expect_val(0); check("disturb_err", 32'(err1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
